// File: rtl/sqrt_range_ctrl_if.sv
// Handshake and evaluator bus for sqrt_range_ctrl.
// master: operand producer / result consumer / sqrt evaluator side.
// slave:  the range-reduction controller itself.
interface sqrt_range_ctrl_if;
    logic [30:0] e_i;           // operand, unsigned 6.25
    logic        in_valid_i;
    logic        in_ready_o;
    logic [30:0] sq_x_f_o;      // mantissa fraction to the evaluator
    logic        sq_polysel_o;  // 1 = [1,2) table, 0 = [2,4) table
    logic [19:0] sq_y_f_i;      // evaluator result, unsigned 2.18
    logic [23:0] f_o;           // sqrt(e), unsigned 3.21
    logic        out_valid_o;
    logic        out_ready_i;

    modport master (
        output e_i, in_valid_i, sq_y_f_i, out_ready_i,
        input  in_ready_o, sq_x_f_o, sq_polysel_o, f_o, out_valid_o
    );

    modport slave (
        input  e_i, in_valid_i, sq_y_f_i, out_ready_i,
        output in_ready_o, sq_x_f_o, sq_polysel_o, f_o, out_valid_o
    );
endinterface

// File: rtl/sqrt_range_ctrl.sv
// Range-reduction / reconstruction controller around the piecewise-linear
// sqrt evaluator. Normalises e to mantissa/exponent, feeds the evaluator,
// then rescales its result by half the exponent.
// Optional feature: define SQRT_COARSE_SHIFT_EN to allow 8-bit normalisation
// steps (same results, shorter latency for small operands).
module sqrt_range_ctrl (
    input  logic               clk,
    input  logic               reset,
    sqrt_range_ctrl_if.slave   bus
);

    typedef enum logic [2:0] {StIdle, StNorm, StEval, StDenorm, StDone} state_e;

    state_e             state_q, state_d;
    logic [30:0]        sh_q, sh_d;
    logic signed [5:0]  exp_q, exp_d;       // p - 25, range -25..+5
    logic signed [4:0]  k_q, k_d;           // exp >>> 1, range -13..+2
    logic [19:0]        y_q, y_d;
    logic [30:0]        x_f_q, x_f_d;
    logic               polysel_q, polysel_d;
    logic [23:0]        f_q, f_d;
    logic               out_valid_q, out_valid_d;

    // Reconstruction datapath signals
    logic [5:0]         shamt;              // 3 + k, two's complement, -10..+5
    logic [5:0]         rshamt;             // -(3 + k) when shamt is negative
    logic [29:0]        scaled;             // wide enough for y << 5
    logic [23:0]        f_scaled;

    // Rescale captured y by 2^(3+k) with truncation on right shifts and saturation
    always_comb begin
        shamt    = {k_q[4], k_q} + 6'd3;
        rshamt   = 6'd0 - shamt;
        scaled   = '0;
        f_scaled = '0;
        if (!shamt[5]) begin
            scaled = {10'd0, y_q} << shamt[2:0];
        end else begin
            scaled = {10'd0, y_q} >> rshamt[3:0];
        end
        f_scaled = (|scaled[29:24]) ? 24'hFF_FFFF : scaled[23:0];
    end

    // Next-state and register-update decode
    always_comb begin
        state_d   = state_q;
        sh_d      = sh_q;
        exp_d     = exp_q;
        k_d       = k_q;
        y_d       = y_q;
        x_f_d     = x_f_q;
        polysel_d = polysel_q;
        f_d       = f_q;

        unique case (state_q)
            StIdle: begin
                if (bus.in_valid_i) begin
                    sh_d  = bus.e_i;
                    exp_d = 6'sd5;
                    if (bus.e_i == '0) begin
                        f_d     = '0;
                        state_d = StDone;
                    end else begin
                        state_d = StNorm;
                    end
                end
            end
            StNorm: begin
                if (sh_q[30]) begin
                    // Fraction bits are the same for even and odd exponents;
                    // odd exponents use the [2,4) table.
                    x_f_d     = {sh_q[29:0], 1'b0};
                    polysel_d = ~exp_q[0];
                    k_d       = 5'(exp_q >>> 1);
                    state_d   = StEval;
                end
`ifdef SQRT_COARSE_SHIFT_EN
                else if (sh_q[30:23] == 8'd0) begin
                    sh_d  = {sh_q[22:0], 8'd0};
                    exp_d = exp_q - 6'sd8;
                end
`endif
                else begin
                    sh_d  = {sh_q[29:0], 1'b0};
                    exp_d = exp_q - 6'sd1;
                end
            end
            StEval: begin
                // Evaluator inputs have been stable for a full cycle here
                y_d     = bus.sq_y_f_i;
                state_d = StDenorm;
            end
            StDenorm: begin
                f_d     = f_scaled;
                state_d = StDone;
            end
            StDone: begin
                if (bus.out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        out_valid_d = (state_d == StDone);
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            sh_q        <= '0;
            exp_q       <= '0;
            k_q         <= '0;
            y_q         <= '0;
            x_f_q       <= '0;
            polysel_q   <= 1'b0;
            f_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            exp_q       <= exp_d;
            k_q         <= k_d;
            y_q         <= y_d;
            x_f_q       <= x_f_d;
            polysel_q   <= polysel_d;
            f_q         <= f_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready_o   = (state_q == StIdle);
    assign bus.sq_x_f_o     = x_f_q;
    assign bus.sq_polysel_o = polysel_q;
    assign bus.f_o          = f_q;
    assign bus.out_valid_o  = out_valid_q;

endmodule

// File: tb/tb_sqrt_range_ctrl.sv
// Directed self-checking bench for sqrt_range_ctrl. The sqrt evaluator is
// stood in for by a per-table constant, optionally overridden.
module tb_sqrt_range_ctrl;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic        y_force_en;
    logic [19:0] y_force;
    logic [23:0] f_hold;

    sqrt_range_ctrl_if bus ();

    sqrt_range_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Evaluator stand-in: combinational from polysel
    always_comb begin
        if (y_force_en) bus.sq_y_f_i = y_force;
        else            bus.sq_y_f_i = bus.sq_polysel_o ? 20'h403FB : 20'h5ADC9;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Called #1 after an edge while idle; returns #1 after the accept edge
    task automatic start_op(input logic [30:0] e);
        check("accept_ready", {31'd0, bus.in_ready_o}, 32'd1);
        bus.e_i        = e;
        bus.in_valid_i = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid_i = 1'b0;
    endtask

    task automatic wait_result(input string tag, input int want_lat, input logic [23:0] want_f,
                               input logic want_pol, input logic [30:0] want_xf);
        int lat = 0;
        while (!bus.out_valid_o && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_lat"}, lat, want_lat);
        check({tag, "_f"}, {8'd0, bus.f_o}, {8'd0, want_f});
        check({tag, "_pol"}, {31'd0, bus.sq_polysel_o}, {31'd0, want_pol});
        check({tag, "_xf"}, {1'b0, bus.sq_x_f_o}, {1'b0, want_xf});
    endtask

    task automatic handshake();
        bus.out_ready_i = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready_i = 1'b0;
        check("hs_valid_low", {31'd0, bus.out_valid_o}, 32'd0);
        check("hs_ready", {31'd0, bus.in_ready_o}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat_tiny;
`ifdef SQRT_COARSE_SHIFT_EN
        lat_tiny = 12;
`else
        lat_tiny = 33;
`endif
        reset           = 1'b1;
        bus.e_i         = '0;
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b0;
        y_force_en      = 1'b0;
        y_force         = '0;
        #1;
        check("rst_in_ready", {31'd0, bus.in_ready_o}, 32'd1);
        check("rst_out_valid", {31'd0, bus.out_valid_o}, 32'd0);
        check("rst_f", {8'd0, bus.f_o}, 32'd0);
        check("rst_xf", {1'b0, bus.sq_x_f_o}, 32'd0);
        check("rst_pol", {31'd0, bus.sq_polysel_o}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // e = 1.0, 2.0, 4.0, 2^-25
        start_op(31'h0200_0000);
        wait_result("e1p0", 8, 24'h201FD8, 1'b1, 31'h0);
        handshake();
        start_op(31'h0400_0000);
        wait_result("e2p0", 7, 24'h2D6E48, 1'b0, 31'h0);
        handshake();
        start_op(31'h0800_0000);
        wait_result("e4p0", 6, 24'h403FB0, 1'b1, 31'h0);
        handshake();
        start_op(31'h0000_0001);
        wait_result("etiny", lat_tiny, 24'h00016B, 1'b0, 31'h0);
        handshake();

        // Largest shift with a large y: saturates
        y_force_en = 1'b1;
        y_force    = 20'hFFFFF;
        start_op(31'h4000_0000);
        wait_result("sat", 3, 24'hFF_FFFF, 1'b0, 31'h0);
        handshake();

        // Zero operand: y ignored, valid in the first cycle after accept
        y_force = 20'h12345;
        start_op(31'h0);
        wait_result("zero", 0, 24'h0, 1'b0, 31'h0);
        handshake();
        y_force_en = 1'b0;

        // Backpressure: result held, new operand waits for the handshake
        start_op(31'h0200_0000);
        wait_result("bp", 8, 24'h201FD8, 1'b1, 31'h0);
        f_hold         = bus.f_o;
        bus.e_i        = 31'h0300_0000;
        bus.in_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_valid", {31'd0, bus.out_valid_o}, 32'd1);
            check("bp_f", {8'd0, bus.f_o}, {8'd0, f_hold});
            check("bp_in_ready", {31'd0, bus.in_ready_o}, 32'd0);
        end
        bus.out_ready_i = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready_i = 1'b0;
        check("bp_hs_valid", {31'd0, bus.out_valid_o}, 32'd0);
        check("bp_hs_ready", {31'd0, bus.in_ready_o}, 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid_i = 1'b0;
        check("bp_reaccept", {31'd0, bus.in_ready_o}, 32'd0);
        wait_result("e1p5", 8, 24'h201FD8, 1'b1, 31'h4000_0000);
        handshake();

        // Asynchronous reset in the middle of NORM
        start_op(31'h0000_0001);
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("mid_in_ready", {31'd0, bus.in_ready_o}, 32'd1);
        check("mid_out_valid", {31'd0, bus.out_valid_o}, 32'd0);
        check("mid_f", {8'd0, bus.f_o}, 32'd0);
        check("mid_xf", {1'b0, bus.sq_x_f_o}, 32'd0);
        check("mid_pol", {31'd0, bus.sq_polysel_o}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        start_op(31'h0200_0000);
        wait_result("post_rst", 8, 24'h201FD8, 1'b1, 31'h0);
        handshake();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
